// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode constants, datapath widths and the
// fetch-stage action encoding used by the instruction-fetch front end.
package legv8_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 64;

  localparam logic [5:0] OPC_B  = 6'b000101;
  localparam logic [5:0] OPC_BL = 6'b100101;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [1:0] {
    FETCH_ADVANCE  = 2'd0,
    FETCH_STALL    = 2'd1,
    FETCH_REDIRECT = 2'd2
  } fetch_action_e;

  function automatic logic opcode_is_b(input logic [INSTR_W-1:0] instr);
    return instr[31:26] == OPC_B;
  endfunction

  function automatic logic opcode_is_bl(input logic [INSTR_W-1:0] instr);
    return instr[31:26] == OPC_BL;
  endfunction

endpackage

// File: rtl/branch_predecode.sv
// Combinational pre-decode of unconditional B/BL and their PC-relative target,
// shared by the fetch stage and any future branch-target buffer.
module branch_predecode
  import legv8_pkg::*;
#(
  parameter int unsigned ADDR_W = legv8_pkg::PC_W
) (
  input  logic [INSTR_W-1:0] rom_data,
  input  logic [ADDR_W-1:0]  pc,
  output logic               is_b,
  output logic               is_bl,
  output logic [ADDR_W-1:0]  br_tgt
);

  logic [ADDR_W-1:0] offset;

  // imm26 is a word offset: sign-extend and scale to bytes; the add wraps.
  assign offset = {{(ADDR_W-28){rom_data[25]}}, rom_data[25:0], 2'b00};
  assign is_b   = opcode_is_b(rom_data);
  assign is_bl  = opcode_is_bl(rom_data);
  assign br_tgt = pc + offset;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, IF/ID output register with a
// valid/ready handshake, zero-bubble B/BL redirect and downstream redirects.
module fetch_stage
  import legv8_pkg::*;
#(
  parameter int unsigned      PC_W     = legv8_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(legv8_pkg::RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [31:0]         rom_addr,
  input  logic [INSTR_W-1:0]  rom_data,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_target,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [PC_W-1:0]     if_pc,
  output logic [PC_W-1:0]     if_link,
  output logic                if_taken,
  output logic                misalign_err
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [PC_W-1:0]    if_link_q, if_link_d;
  logic               if_taken_q, if_taken_d;
  logic               misalign_q, misalign_d;

  logic               accept;
  logic               is_b;
  logic               is_bl;
  logic [PC_W-1:0]    br_tgt;
  logic [PC_W-1:0]    pc_plus4;
  fetch_action_e      action;

  branch_predecode #(
    .ADDR_W (PC_W)
  ) u_predecode (
    .rom_data (rom_data),
    .pc       (pc_q),
    .is_b     (is_b),
    .is_bl    (is_bl),
    .br_tgt   (br_tgt)
  );

  assign accept   = !if_valid_q || if_ready;
  assign pc_plus4 = pc_q + PC_W'(4);

  always_comb begin
    action = FETCH_ADVANCE;
    if (redirect_valid) begin
      action = FETCH_REDIRECT;
    end else if (!accept) begin
      action = FETCH_STALL;
    end
  end

  // A redirect flushes the IF/ID register even while decode is stalled.
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_link_d  = if_link_q;
    if_taken_d = if_taken_q;
    misalign_d = misalign_q;
    unique case (action)
      FETCH_REDIRECT: begin
        pc_d       = {redirect_target[PC_W-1:2], 2'b00};
        if_valid_d = 1'b0;
        if (redirect_target[1:0] != 2'b00) begin
          misalign_d = 1'b1;
        end
      end
      FETCH_ADVANCE: begin
        if_valid_d = 1'b1;
        if_instr_d = rom_data;
        if_pc_d    = pc_q;
        if_link_d  = pc_plus4;
        if_taken_d = is_b || is_bl;
        pc_d       = (is_b || is_bl) ? br_tgt : pc_plus4;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_link_q  <= '0;
      if_taken_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_link_q  <= if_link_d;
      if_taken_q <= if_taken_d;
      misalign_q <= misalign_d;
    end
  end

  assign rom_addr     = pc_q[31:0];
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_link      = if_link_q;
  assign if_taken     = if_taken_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle-level reference model of the
// fetch rules plus directed literal checks and a randomized stress phase.
module tb_fetch_stage;

  localparam logic [31:0] BR_X11 = 32'hD61F0160;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [63:0] if_link;
  logic        if_taken;
  logic        misalign_err;

  logic [31:0] rom [256];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] ifpc;
    logic [63:0] link;
    logic        taken;
    logic        mis;
  } model_t;

  model_t m;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_link         (if_link),
    .if_taken        (if_taken),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr[9:2]];

  function automatic logic [31:0] movz_word(input int idx);
    return 32'hD2800000 | (32'(idx) << 5);
  endfunction

  // Reference model: what one rising edge does, straight from the fetch rules.
  function automatic model_t model_step(input model_t s, input logic redir,
                                        input logic [63:0] tgt, input logic rdy);
    model_t n;
    logic [31:0] w;
    longint off;
    n = s;
    if (redir) begin
      n.pc    = tgt - 64'(tgt % 4);
      n.valid = 1'b0;
      if (tgt % 4 != 0) n.mis = 1'b1;
    end else if (!s.valid || rdy) begin
      w       = rom[s.pc[9:2]];
      n.valid = 1'b1;
      n.instr = w;
      n.ifpc  = s.pc;
      n.link  = s.pc + 64'd4;
      n.taken = (w[31:26] == 6'd5) || (w[31:26] == 6'd37);
      if (n.taken) begin
        off  = longint'($signed(w[25:0])) * 4;
        n.pc = s.pc + 64'(off);
      end else begin
        n.pc = s.pc + 64'd4;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, redirect_valid, redirect_target, if_ready);
  end

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Every cycle, all outputs must agree with the model.
  always @(negedge clk) begin
    check_output("model.rom_addr", 64'(rom_addr), 64'(m.pc[31:0]));
    check_output("model.if_valid", 64'(if_valid), 64'(m.valid));
    check_output("model.if_instr", 64'(if_instr), 64'(m.instr));
    check_output("model.if_pc", if_pc, m.ifpc);
    check_output("model.if_link", if_link, m.link);
    check_output("model.if_taken", 64'(if_taken), 64'(m.taken));
    check_output("model.misalign", 64'(misalign_err), 64'(m.mis));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_and_check(input logic [63:0] exp_pc, input logic exp_taken);
    tick();
    check_output("seq.if_valid", 64'(if_valid), 64'd1);
    check_output("seq.if_pc", if_pc, exp_pc);
    check_output("seq.if_link", if_link, exp_pc + 64'd4);
    check_output("seq.if_taken", 64'(if_taken), 64'(exp_taken));
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (c == cycles / 2) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      if_ready        = ($urandom % 4) != 0;
      redirect_valid  = ($urandom % 16) == 0;
      redirect_target = {$urandom, $urandom};
      if (($urandom % 4) != 0) redirect_target[1:0] = 2'b00;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [25:0] imm;
    for (int i = 0; i < 256; i++) rom[i] = movz_word(i);
    rom[7]  = 32'h14000001;
    rom[8]  = 32'h17FFFFF9;
    rom[20] = BR_X11;
    rst_n           = 1'b0;
    if_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    #1;
    check_output("reset.if_valid", 64'(if_valid), 64'd0);
    check_output("reset.rom_addr", 64'(rom_addr), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int a = 0; a <= 'h18; a += 4) fetch_and_check(64'(a), 1'b0);
    fetch_and_check(64'h1C, 1'b1);
    check_output("b.if_instr", 64'(if_instr), 64'h14000001);
    fetch_and_check(64'h20, 1'b1);
    fetch_and_check(64'h04, 1'b0);
    rom[5] = 32'h9400000A;
    for (int a = 8; a <= 'h10; a += 4) fetch_and_check(64'(a), 1'b0);
    fetch_and_check(64'h14, 1'b1);
    check_output("bl.if_link", if_link, 64'h18);
    fetch_and_check(64'h3C, 1'b0);

    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("stall.if_pc", if_pc, 64'h3C);
      check_output("stall.if_instr", 64'(if_instr), 64'(movz_word(15)));
      check_output("stall.rom_addr", 64'(rom_addr), 64'h40);
    end
    if_ready = 1'b1;
    fetch_and_check(64'h40, 1'b0);
    fetch_and_check(64'h44, 1'b0);

    if_ready = 1'b0;
    tick();
    check_output("stall2.if_pc", if_pc, 64'h44);
    redirect_valid  = 1'b1;
    redirect_target = 64'h48;
    tick();
    check_output("redir.if_valid", 64'(if_valid), 64'd0);
    check_output("redir.rom_addr", 64'(rom_addr), 64'h48);
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    fetch_and_check(64'h48, 1'b0);
    check_output("redir.misalign", 64'(misalign_err), 64'd0);

    redirect_valid  = 1'b1;
    redirect_target = 64'h4A;
    tick();
    check_output("mis.rom_addr", 64'(rom_addr), 64'h48);
    check_output("mis.flag", 64'(misalign_err), 64'd1);
    redirect_valid = 1'b0;
    fetch_and_check(64'h48, 1'b0);
    for (int k = 0; k < 10; k++) fetch_and_check(64'h4C + 64'(4 * k), 1'b0);
    check_output("mis.sticky", 64'(misalign_err), 64'd1);
    check_output("brx11.passes", 64'(rom[20]), 64'(BR_X11));

    redirect_valid  = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_and_check(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    check_output("wrap.if_link", if_link, 64'h0);
    fetch_and_check(64'h0, 1'b0);

    redirect_valid  = 1'b1;
    redirect_target = 64'h30;
    tick();
    redirect_valid = 1'b0;
    check_output("midrst.rom_addr_before", 64'(rom_addr), 64'h30);
    rst_n = 1'b0;
    #1;
    check_output("midrst.rom_addr", 64'(rom_addr), 64'h0);
    check_output("midrst.if_valid", 64'(if_valid), 64'd0);
    check_output("midrst.if_instr", 64'(if_instr), 64'd0);
    check_output("midrst.if_pc", if_pc, 64'd0);
    check_output("midrst.if_link", if_link, 64'd0);
    check_output("midrst.if_taken", 64'(if_taken), 64'd0);
    check_output("midrst.misalign", 64'(misalign_err), 64'd0);
    tick();
    rst_n = 1'b1;
    fetch_and_check(64'h0, 1'b0);

    // Random program: mostly sequential words, short B/BL hops, self-loops.
    for (int i = 0; i < 256; i++) begin
      imm = 26'($signed($urandom_range(0, 32)) - 16);
      case ($urandom % 10)
        0, 1:    rom[i] = {6'b000101, imm};
        2:       rom[i] = {6'b100101, imm};
        3:       rom[i] = BR_X11;
        4:       rom[i] = $urandom;
        5:       rom[i] = (($urandom % 4) == 0) ? 32'h14000000 : movz_word(i);
        default: rom[i] = movz_word(i);
      endcase
    end
    apply_stimulus(3000);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
